reg_pipeline: RTL and testbench
===============================

Name: reg_pipeline

Overview:
Parametrised multi-bit, multi-stage register pipeline with per-stage valid bits, stall (enable), flush and a selectable read tap. It generalises the single-bit D flip-flop into a WIDTH x DEPTH delay line. The vending-machine datapath uses it to delay and align coin and selection events with their qualifying valid flags. It also tracks how many stages currently hold valid data.

Parameters:
WIDTH, 8, data bits per stage (>=1)
DEPTH, 4, number of register stages (>=1)
RESET_VAL, 0, value loaded into every stage data register on reset/flush (WIDTH bits)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset)
en  input  1  advance pipeline one stage when 1; hold all state when 0
flush  input  1  synchronous clear of all stages (valid and data)
d  input  WIDTH  data into stage 0
d_valid  input  1  valid flag into stage 0
tap_sel  input  max(1,$clog2(DEPTH))  stage index for tap outputs
q  output  WIDTH  data of last stage (DEPTH-1)
q_valid  output  1  valid of last stage
tap_q  output  WIDTH  data of stage tap_sel
tap_valid  output  1  valid of stage tap_sel
count  output  $clog2(DEPTH+1)  number of stages with valid=1

Behaviour:
- State: data[0..DEPTH-1] (WIDTH each), valid[0..DEPTH-1], count register.
- Priority at each rising edge: rst==0 > flush==1 > en==1 > hold.
- Reset (rst==0): all data=RESET_VAL, all valid=0, count=0. Therefore q=RESET_VAL, q_valid=0, tap_valid=0 the cycle after reset. Reset mid-stream discards all contents, whatever en or flush is doing.
- Flush (rst==1, flush==1): same effect as reset. d/d_valid on that edge are discarded, even if en==1.
- Advance (en==1):
  - data[0]<=d, valid[0]<=d_valid.
  - data[i]<=data[i-1], valid[i]<=valid[i-1] for i=1..DEPTH-1.
  - Data shifts regardless of valid. Invalid stages still carry their data bits.
- Hold (en==0): all data, valid and count unchanged. d/d_valid are ignored.
- Latency: with en held high, a word presented at edge k appears on q/q_valid after edge k+DEPTH-1 (DEPTH register stages; q is stage DEPTH-1). Stalled cycles add one cycle each.
- count update on advance: count_next = count + d_valid - valid[DEPTH-1].
  - Simultaneous entry and exit leaves count unchanged.
  - count never exceeds DEPTH and never underflows.
  - count holds on stall and goes to 0 on reset/flush.
  - Invariant: count == popcount(valid) at all times.
- q, q_valid: direct register outputs of stage DEPTH-1 (no combinational path from inputs).
- tap_q/tap_valid: combinational mux of the registered stages by tap_sel.
  - tap_sel >= DEPTH (possible when DEPTH is not a power of 2): tap_q=RESET_VAL, tap_valid=0.
  - No path from d or en to any output within a cycle.
- DEPTH=1: single stage; tap_sel is 1 bit, and tap_sel=1 is out of range. Latency is one edge.
- No X propagation: all outputs are defined from the first edge with rst==0.

Test Plan:
1. Reset: WIDTH=8, DEPTH=4, RESET_VAL=8'hA5; hold rst=0 for 2 edges with d=8'hFF, d_valid=1, en=1 -> q=8'hA5, q_valid=0, count=0; tap_q=8'hA5 for all tap_sel.
2. Streaming latency: rst=1, en=1; d=1,2,3,4,5 with d_valid=1 on consecutive edges -> q_valid first rises after the 4th edge with q=1, then q=2,3,4,5; count reads 1,2,3,4,4.
3. Stall: after loading 1..3, drop en for 3 edges with d=8'h77, d_valid=1 -> all stages, q and count (3) unchanged. Raise en -> sequence resumes with 8'h77 entering stage 0.
4. Bubbles and tap: inputs (10,v=1),(20,v=0),(30,v=1),(40,v=0) -> count=2. tap_sel=1 gives tap_q=30, tap_valid=1. tap_sel=2 gives tap_q=20, tap_valid=0.
5. Flush vs enable: pipe full (count=4); assert flush=1, en=1, d=8'h99, d_valid=1 for one edge -> count=0, q_valid=0, q=RESET_VAL; 8'h99 never emerges.
6. Reset mid-operation, plus DEPTH=3 and DEPTH=1 builds:
   - DEPTH=3: rst=0 while count=2 -> count=0 next edge. tap_sel=3 gives tap_q=RESET_VAL, tap_valid=0.
   - DEPTH=1: d=8'h3C, d_valid=1 -> q=8'h3C, q_valid=1 after one edge.

Source files
------------

// File: rtl/reg_pipeline.sv
// WIDTH x DEPTH register delay line with per-stage valid flags, stall, flush,
// a selectable read tap and a running count of occupied stages.
module reg_pipeline #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [TW-1:0]    tap_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_valid,
    output logic [CW-1:0]    count
);

    localparam int TAPS = 2 ** TW;

    logic [WIDTH-1:0] data_reg [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;

    logic [WIDTH-1:0] shift_data [DEPTH];
    logic [DEPTH-1:0] shift_valid;
    logic [WIDTH-1:0] tap_data [TAPS];
    logic [TAPS-1:0]  tap_vld;
    logic             clear;

    assign clear = !rst || flush;

    // Input of each stage: the external word for stage 0, the previous stage otherwise.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_shift
            if (gi == 0) begin : g_head
                assign shift_data[gi]  = d;
                assign shift_valid[gi] = d_valid;
            end else begin : g_body
                assign shift_data[gi]  = data_reg[gi-1];
                assign shift_valid[gi] = valid_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= RESET_VAL;
            end
            valid_reg <= '0;
        end else if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= shift_data[i];
            end
            valid_reg <= shift_valid;
        end
    end

    // Occupancy moves only when exactly one of entry/exit carries a valid word.
    always_comb begin
        count_next = count_reg;
        if (d_valid && !valid_reg[DEPTH-1]) begin
            count_next = count_reg + CW'(1);
        end else if (!d_valid && valid_reg[DEPTH-1]) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_next;
        end
    end

    // Tap table padded to a power of two so out-of-range selects read as empty.
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_tap
            if (gi < DEPTH) begin : g_live
                assign tap_data[gi] = data_reg[gi];
                assign tap_vld[gi]  = valid_reg[gi];
            end else begin : g_pad
                assign tap_data[gi] = RESET_VAL;
                assign tap_vld[gi]  = 1'b0;
            end
        end
    endgenerate

    assign q         = data_reg[DEPTH-1];
    assign q_valid   = valid_reg[DEPTH-1];
    assign tap_q     = tap_data[tap_sel];
    assign tap_valid = tap_vld[tap_sel];
    assign count     = count_reg;

endmodule

// File: tb/tb_reg_pipeline.sv
// Bench for reg_pipeline: three builds (DEPTH 4/3/1) share one stimulus stream and
// are compared every cycle against a history-of-accepted-words model.
module tb_reg_pipeline;

    logic       clk = 1'b0;
    logic       rst, en, flush, d_valid;
    logic [7:0] d;

    logic [1:0] sel4;
    logic [1:0] sel3;
    logic       sel1;
    logic [7:0] q4, q3, q1, tq4, tq3, tq1;
    logic       qv4, qv3, qv1, tv4, tv3, tv1;
    logic [2:0] cnt4;
    logic [1:0] cnt3;
    logic       cnt1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit model_ok = 1'b0;

    localparam logic [7:0] RV4 = 8'hA5;
    localparam logic [7:0] RV3 = 8'h5A;
    localparam logic [7:0] RV1 = 8'h00;

    always #5 clk = ~clk;

    reg_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .tap_sel(sel4), .q(q4), .q_valid(qv4), .tap_q(tq4), .tap_valid(tv4), .count(cnt4));

    reg_pipeline #(.WIDTH(8), .DEPTH(3), .RESET_VAL(RV3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .tap_sel(sel3), .q(q3), .q_valid(qv3), .tap_q(tq3), .tap_valid(tv3), .count(cnt3));

    reg_pipeline #(.WIDTH(8), .DEPTH(1), .RESET_VAL(RV1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .tap_sel(sel1), .q(q1), .q_valid(qv1), .tap_q(tq1), .tap_valid(tv1), .count(cnt1));

    // Model: the most recent accepted words; stage i holds the i-th newest one.
    typedef struct {
        logic [7:0] data;
        bit         valid;
        bit         fill;
    } ent_t;
    ent_t hist[$];

    always @(posedge clk) begin
        if (!rst || flush) begin
            hist.delete();
            for (int i = 0; i < 4; i++) hist.push_back('{data: 8'h00, valid: 1'b0, fill: 1'b1});
            model_ok = 1'b1;
        end else if (en && model_ok) begin
            hist.push_back('{data: d, valid: d_valid, fill: 1'b0});
            if (hist.size() > 4) void'(hist.pop_front());
        end
    end

    function automatic logic [7:0] m_data(int i, logic [7:0] rv);
        ent_t e = hist[hist.size() - 1 - i];
        return e.fill ? rv : e.data;
    endfunction

    function automatic bit m_valid(int i);
        ent_t e = hist[hist.size() - 1 - i];
        return e.valid;
    endfunction

    function automatic int m_count(int depth);
        int c = 0;
        for (int i = 0; i < depth; i++) c += int'(m_valid(i));
        return c;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmp(string tag, int depth, logic [7:0] rv, int sel,
                       logic [7:0] q, logic qv, logic [7:0] tq, logic tv, int cnt);
        check({tag, ".q"}, 32'(q), 32'(m_data(depth - 1, rv)));
        check({tag, ".q_valid"}, 32'(qv), 32'(m_valid(depth - 1)));
        check({tag, ".count"}, 32'(cnt), 32'(m_count(depth)));
        if (sel < depth) begin
            check({tag, ".tap_q"}, 32'(tq), 32'(m_data(sel, rv)));
            check({tag, ".tap_valid"}, 32'(tv), 32'(m_valid(sel)));
        end else begin
            check({tag, ".tap_q_oor"}, 32'(tq), 32'(rv));
            check({tag, ".tap_valid_oor"}, 32'(tv), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            cmp("d4", 4, RV4, int'(sel4), q4, qv4, tq4, tv4, int'(cnt4));
            cmp("d3", 3, RV3, int'(sel3), q3, qv3, tq3, tv3, int'(cnt3));
            cmp("d1", 1, RV1, int'(sel1), q1, qv1, tq1, tv1, int'(cnt1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        sel4 = 2'(cyc);
        sel3 = 2'(cyc);
        sel1 = 1'(cyc);
        $display("cyc=%0d rst=%0b en=%0b fl=%0b d=%02h dv=%0b | q4=%02h/%0b cnt4=%0d q3=%02h/%0b cnt3=%0d q1=%02h/%0b",
                 cyc, rst, en, flush, d, d_valid, q4, qv4, cnt4, q3, qv3, cnt3, q1, qv1);
    endtask

    task automatic drive(logic [7:0] dv_d, logic dv_v);
        d = dv_d;
        d_valid = dv_v;
        tick();
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; flush = 1'b0; d = 8'hFF; d_valid = 1'b1;
        sel4 = '0; sel3 = '0; sel1 = 1'b0;

        // Reset with live-looking inputs
        tick(); tick();
        check("rst.q", 32'(q4), 32'hA5);
        check("rst.q_valid", 32'(qv4), 32'd0);
        check("rst.count", 32'(cnt4), 32'd0);
        for (int s = 0; s < 4; s++) begin
            sel4 = 2'(s);
            #1;
            check("rst.tap_q", 32'(tq4), 32'hA5);
        end

        // Streaming latency
        rst = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            drive(8'(v), 1'b1);
            check("stream.count", 32'(cnt4), 32'((v < 4) ? v : 4));
            check("stream.q_valid", 32'(qv4), 32'(v >= 4));
            check("stream.q", 32'(q4), (v >= 4) ? 32'(v - 3) : 32'hA5);
        end

        // Stall
        rst = 1'b0; tick(); rst = 1'b1;
        for (int v = 1; v <= 3; v++) drive(8'(v), 1'b1);
        en = 1'b0;
        for (int k = 0; k < 3; k++) drive(8'h77, 1'b1);
        check("stall.count", 32'(cnt4), 32'd3);
        check("stall.q", 32'(q4), 32'hA5);
        sel4 = 2'd1; #1;
        check("stall.tap1", 32'(tq4), 32'd2);
        en = 1'b1;
        drive(8'h77, 1'b1);
        sel4 = 2'd0; #1;
        check("resume.tap0", 32'(tq4), 32'h77);
        check("resume.count", 32'(cnt4), 32'd4);
        drive(8'h00, 1'b0);
        check("resume.q", 32'(q4), 32'd2);

        // Bubbles and tap
        flush = 1'b1; tick(); flush = 1'b0;
        drive(8'd10, 1'b1); drive(8'd20, 1'b0); drive(8'd30, 1'b1); drive(8'd40, 1'b0);
        check("bubble.count", 32'(cnt4), 32'd2);
        sel4 = 2'd1; #1;
        check("bubble.tap1_q", 32'(tq4), 32'd30);
        check("bubble.tap1_v", 32'(tv4), 32'd1);
        sel4 = 2'd2; #1;
        check("bubble.tap2_q", 32'(tq4), 32'd20);
        check("bubble.tap2_v", 32'(tv4), 32'd0);

        // Flush beats enable
        for (int v = 0; v < 4; v++) drive(8'(8'h50 + v), 1'b1);
        check("full.count", 32'(cnt4), 32'd4);
        flush = 1'b1;
        drive(8'h99, 1'b1);
        flush = 1'b0;
        check("flush.count", 32'(cnt4), 32'd0);
        check("flush.q_valid", 32'(qv4), 32'd0);
        check("flush.q", 32'(q4), 32'hA5);
        for (int k = 0; k < 3; k++) begin
            drive(8'h00, 1'b0);
            check("flush.q_after", 32'(q4), 32'hA5);
        end
        drive(8'h00, 1'b0);
        check("flush.q_tail", 32'(q4), 32'h00);

        // Reset mid-stream on DEPTH=3, out-of-range tap
        drive(8'h61, 1'b1); drive(8'h62, 1'b1);
        check("d3.count_pre", 32'(cnt3), 32'd2);
        rst = 1'b0;
        drive(8'h63, 1'b1);
        check("d3.count_rst", 32'(cnt3), 32'd0);
        sel3 = 2'd3; #1;
        check("d3.tap_oor_q", 32'(tq3), 32'h5A);
        check("d3.tap_oor_v", 32'(tv3), 32'd0);

        // DEPTH=1 single-edge latency
        rst = 1'b1;
        drive(8'h3C, 1'b1);
        check("d1.q", 32'(q1), 32'h3C);
        check("d1.q_valid", 32'(qv1), 32'd1);
        check("d1.count", 32'(cnt1), 32'd1);
        sel1 = 1'b1; #1;
        check("d1.tap_oor_v", 32'(tv1), 32'd0);
        drive(8'h00, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
